// File: rtl/bmem_burst_ctrl.sv
// Cache-line (256-bit) to burst-memory (4 x 64-bit beat) controller.
// Optional macro BMEM_RADDR_CHECK_EN: accept read beats only for the latched line address.
module bmem_burst_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  req_addr,
  input  logic         req_read,
  input  logic         req_write,
  input  logic [255:0] req_wdata,
  output logic         req_ready,
  output logic         resp_valid,
  output logic [255:0] resp_rdata,
  output logic [31:0]  bmem_addr,
  output logic         bmem_read,
  output logic         bmem_write,
  output logic [63:0]  bmem_wdata,
  input  logic         bmem_ready,
  input  logic [31:0]  bmem_raddr,
  input  logic [63:0]  bmem_rdata,
  input  logic         bmem_rvalid
);

  typedef enum logic [2:0] {IDLE, WR_BEAT, RD_CMD, RD_WAIT, DONE} state_t;

  state_t       state_reg, state_next;
  logic [1:0]   cnt_reg, cnt_next;
  logic [31:0]  addr_reg;
  logic         op_write_reg;
  logic [63:0]  line_reg [4];
  logic [255:0] line_flat;
  logic         beat_ok;
  logic         unused_bits;

`ifdef BMEM_RADDR_CHECK_EN
  assign beat_ok     = bmem_rvalid && (bmem_raddr[31:5] == addr_reg[31:5]);
  assign unused_bits = ^{req_addr[4:0], bmem_raddr[4:0]};
`else
  assign beat_ok     = bmem_rvalid;
  assign unused_bits = ^{req_addr[4:0], bmem_raddr};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (req_write) begin
          state_next = WR_BEAT;
          cnt_next   = 2'd0;
        end else if (req_read) begin
          state_next = RD_CMD;
          cnt_next   = 2'd0;
        end
      end
      WR_BEAT: begin
        if (bmem_ready) begin
          cnt_next = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) state_next = DONE;
        end
      end
      RD_CMD: begin
        if (bmem_ready) begin
          state_next = RD_WAIT;
          cnt_next   = 2'd0;
        end
      end
      RD_WAIT: begin
        if (beat_ok) begin
          cnt_next = cnt_reg + 2'd1;
          if (cnt_reg == 2'd3) state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch; write wins when both request strobes are high
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_reg     <= 32'd0;
      op_write_reg <= 1'b0;
    end else if (state_reg == IDLE && (req_read || req_write)) begin
      addr_reg     <= {req_addr[31:5], 5'b0};
      op_write_reg <= req_write;
    end
  end

  // Line buffer holds write data outbound and assembles read beats inbound
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_slot
      always_ff @(posedge clk) begin
        if (rst) begin
          line_reg[gi] <= 64'd0;
        end else if (state_reg == IDLE && req_write) begin
          line_reg[gi] <= req_wdata[gi*64 +: 64];
        end else if (state_reg == IDLE && req_read) begin
          line_reg[gi] <= 64'd0;
        end else if (state_reg == RD_WAIT && beat_ok && cnt_reg == 2'(gi)) begin
          line_reg[gi] <= bmem_rdata;
        end
      end
      assign line_flat[gi*64 +: 64] = line_reg[gi];
    end
  endgenerate

  // Output decode
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = 256'd0;
    bmem_addr  = 32'd0;
    bmem_read  = 1'b0;
    bmem_write = 1'b0;
    bmem_wdata = 64'd0;
    case (state_reg)
      IDLE: req_ready = 1'b1;
      WR_BEAT: begin
        bmem_write = 1'b1;
        bmem_addr  = addr_reg;
        bmem_wdata = line_reg[cnt_reg];
      end
      RD_CMD: begin
        bmem_read = 1'b1;
        bmem_addr = addr_reg;
      end
      DONE: begin
        resp_valid = 1'b1;
        resp_rdata = op_write_reg ? 256'd0 : line_flat;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bmem_burst_ctrl.sv
// Self-checking bench for bmem_burst_ctrl: directed and randomized line reads/writes
// against a beat-level model of the burst memory side.
module tb_bmem_burst_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  req_addr;
  logic         req_read, req_write;
  logic [255:0] req_wdata;
  logic         req_ready, resp_valid;
  logic [255:0] resp_rdata;
  logic [31:0]  bmem_addr;
  logic         bmem_read, bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bmem_burst_ctrl dut (
    .clk(clk), .rst(rst),
    .req_addr(req_addr), .req_read(req_read), .req_write(req_write), .req_wdata(req_wdata),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .bmem_addr(bmem_addr), .bmem_read(bmem_read), .bmem_write(bmem_write), .bmem_wdata(bmem_wdata),
    .bmem_ready(bmem_ready), .bmem_raddr(bmem_raddr), .bmem_rdata(bmem_rdata), .bmem_rvalid(bmem_rvalid)
  );

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_req_ready"},  req_ready,  1'b1);
    check({tag, "_resp_valid"}, resp_valid, 1'b0);
    check({tag, "_resp_rdata"}, resp_rdata, 256'd0);
    check({tag, "_bmem_read"},  bmem_read,  1'b0);
    check({tag, "_bmem_write"}, bmem_write, 1'b0);
    check({tag, "_bmem_addr"},  bmem_addr,  32'd0);
    check({tag, "_bmem_wdata"}, bmem_wdata, 64'd0);
  endtask

  task automatic clear_inputs();
    req_read = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    bmem_ready = 0; bmem_rvalid = 0; bmem_raddr = 0; bmem_rdata = 0;
  endtask

  // Line write: expect 4 beats = line slices in order, each held until accepted.
  task automatic do_write(input logic [31:0] addr, input logic [255:0] wdata,
                          input bit full_ready, input bit also_read);
    logic [31:0] exp_addr;
    int cyc, k, rv, rd_seen;
    exp_addr = {addr[31:5], 5'b0};
    check("wr_req_ready", req_ready, 1'b1);
    req_addr = addr; req_wdata = wdata; req_write = 1; req_read = also_read;
    tick();
    req_write = 0; req_read = 0;
    cyc = 1; k = 0; rv = 0; rd_seen = 0;
    while (cyc < 200 && rv == 0) begin
      if (bmem_read) rd_seen++;
      if (resp_valid) begin
        rv = 1;
        check("wr_beats_accepted", k, 4);
        check("wr_resp_rdata", resp_rdata, 256'd0);
        if (full_ready) check("wr_latency", cyc, 5);
        req_read = 0; req_write = 0; bmem_ready = 0;
      end else begin
        if (k < 4) begin
          check("wr_bmem_write", bmem_write, 1'b1);
          check("wr_bmem_addr", bmem_addr, exp_addr);
          check("wr_bmem_wdata", bmem_wdata, wdata[64*k +: 64]);
        end else begin
          check("wr_extra_beat", bmem_write, 1'b0);
        end
        bmem_ready = full_ready ? 1'b1 : 1'($urandom_range(0, 1));
        req_read  = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        if (bmem_write && bmem_ready) k++;
      end
      tick();
      cyc++;
    end
    check("wr_resp_seen", rv, 1);
    check("wr_no_bmem_read", rd_seen, 0);
    check("wr_resp_one_cycle", resp_valid, 1'b0);
    check("wr_back_idle", req_ready, 1'b1);
  endtask

  // Line read: memory returns line slices as beats 0..3 with random gaps.
  task automatic do_read(input logic [31:0] addr, input logic [255:0] line,
                         input bit full_ready, input int abort_after);
    logic [31:0] exp_addr;
    int cyc, sent, last, rv, rd_cycles;
    bit cmd_acc;
    exp_addr = {addr[31:5], 5'b0};
    check("rd_req_ready", req_ready, 1'b1);
    req_addr = addr; req_read = 1; req_write = 0;
    tick();
    req_read = 0;
    cyc = 1; sent = 0; last = 0; rv = 0; rd_cycles = 0; cmd_acc = 0;
    while (cyc < 300 && rv == 0 && !(abort_after > 0 && sent == abort_after)) begin
      check("rd_no_write", bmem_write, 1'b0);
      if (resp_valid) begin
        rv = 1;
        check("rd_beats_sent", sent, 4);
        check("rd_resp_timing", cyc, last + 1);
        check("rd_resp_rdata", resp_rdata, line);
        req_read = 0; req_write = 0; bmem_rvalid = 0; bmem_ready = 0;
      end else begin
        bmem_rvalid = 0;
        bmem_rdata  = {$urandom, $urandom};
        bmem_raddr  = $urandom;
        if (!cmd_acc) begin
          check("rd_bmem_read", bmem_read, 1'b1);
          check("rd_cmd_addr", bmem_addr, exp_addr);
          rd_cycles++;
          bmem_ready  = full_ready ? 1'b1 : 1'($urandom_range(0, 1));
          bmem_rvalid = 1'($urandom_range(0, 1));
          if (bmem_ready) cmd_acc = 1;
        end else begin
          check("rd_wait_no_read", bmem_read, 1'b0);
          check("rd_wait_addr_zero", bmem_addr, 32'd0);
          bmem_ready = 1'($urandom_range(0, 1));
          if (sent < 4 && $urandom_range(0, 2) != 0) begin
            bmem_rvalid = 1;
            bmem_rdata  = line[64*sent +: 64];
            bmem_raddr  = exp_addr + 32'(sent * 8);
            sent++;
            last = cyc;
          end
`ifdef BMEM_RADDR_CHECK_EN
          else if (sent < 4 && $urandom_range(0, 1) == 0) begin
            bmem_rvalid = 1;
            bmem_raddr  = exp_addr ^ 32'h0000_0100;
          end
`endif
        end
        req_read  = 1'($urandom_range(0, 1));
        req_write = 1'($urandom_range(0, 1));
      end
      tick();
      cyc++;
    end
    req_read = 0; req_write = 0; bmem_rvalid = 0;
    if (abort_after <= 0) begin
      check("rd_resp_seen", rv, 1);
      if (full_ready) check("rd_cmd_cycles", rd_cycles, 1);
      check("rd_resp_one_cycle", resp_valid, 1'b0);
      check("rd_back_idle", req_ready, 1'b1);
    end
  endtask

  initial begin
    logic [255:0] line;
    clear_inputs();
    rst = 1;
    tick();
    tick();
    check_idle("reset_held");
    rst = 0;
    tick();
    check_idle("after_reset");

    // Directed write, ready held high
    do_write(32'h1ECE_B014, {64'h4, 64'h3, 64'h2, 64'h1}, 1, 0);
    // Directed read, beats A..D
    do_read(32'h0000_0040, {64'hD, 64'hC, 64'hB, 64'hA}, 1, 0);
    // Write under backpressure
    line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_write($urandom, line, 0, 0);
    // Simultaneous read and write: write wins
    line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_write($urandom, line, 1, 1);

    // Reset after two read beats
    line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    do_read(32'h0000_1240, line, 1, 2);
    rst = 1;
    bmem_rvalid = 1; bmem_rdata = {$urandom, $urandom};
    tick();
    check_idle("mid_burst_reset");
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      bmem_rvalid = 1; bmem_rdata = {$urandom, $urandom};
      tick();
      check("post_reset_no_resp", resp_valid, 1'b0);
      check("post_reset_idle", req_ready, 1'b1);
    end
    bmem_rvalid = 0;
    do_read(32'h0000_1240, line, 1, 0);

    // Randomized mix
    for (int i = 0; i < 12; i++) begin
      line = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if ($urandom_range(0, 1) == 1)
        do_write($urandom, line, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        do_read($urandom, line, 1'($urandom_range(0, 1)), 0);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bmem_burst_ctrl.md
BMEM_BURST_CTRL -- requirements
Module: bmem_burst_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have ports from the cache arbiter side:
- req_addr  input  32  line address
- req_read  input  1  line read request
- req_write  input  1  line write request
- req_wdata  input  256  write line
REQ-004 SHALL have ports to the cache arbiter side:
- req_ready  output  1  idle, can accept a request
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  256  assembled read line
REQ-005 SHALL have ports to burst memory:
- bmem_addr  output  32  beat/command address
- bmem_read  output  1  read command
- bmem_write  output  1  write beat valid
- bmem_wdata  output  64  write beat data
REQ-006 SHALL have ports from burst memory:
- bmem_ready  input  1  command/beat accepted
- bmem_raddr  input  32  returning beat address
- bmem_rdata  input  64  returning beat data
- bmem_rvalid  input  1  returning beat valid

Function
REQ-007 SHALL implement FSM states IDLE, WR_BEAT, RD_CMD, RD_WAIT and DONE.
REQ-008 SHALL assert req_ready only in IDLE.
REQ-009 In IDLE, SHALL latch the request and a 2-bit beat counter (cnt=0) when req_read or req_write is high:
- latched address = {req_addr[31:5], 5'b0}
- req_wdata latched on write
REQ-010 SHALL give write priority when req_read and req_write are both high; the read is dropped and the requester re-asserts it.
REQ-011 In WR_BEAT, SHALL drive:
- bmem_write=1
- bmem_addr = latched line address
- bmem_wdata = latched line bits [64*cnt+63 : 64*cnt]
REQ-012 In WR_BEAT, SHALL advance cnt only in a cycle with bmem_ready=1; acceptance of beat 3 moves the FSM to DONE.
REQ-013 In RD_CMD, SHALL hold bmem_read=1 and bmem_addr = latched line address until bmem_ready=1, then move to RD_WAIT with cnt=0.
REQ-014 In RD_WAIT, on each bmem_rvalid, SHALL store bmem_rdata into line slot cnt and increment cnt; storing beat 3 moves the FSM to DONE.
REQ-015 In DONE, SHALL assert resp_valid for exactly one cycle, then return to IDLE.
- resp_rdata = assembled line after a read, 0 after a write.
REQ-016 SHALL ignore bmem_rvalid outside RD_WAIT.
REQ-017 SHALL ignore req_read/req_write outside IDLE.
REQ-018 With bmem_ready held 1, write latency from request cycle to resp_valid SHALL be 5 cycles.
REQ-019 With bmem_ready held 1, read resp_valid SHALL occur the cycle after the 4th bmem_rvalid.
REQ-020 SHALL drive all bmem_* outputs to 0 whenever not in WR_BEAT or RD_CMD.

Reset
REQ-021 On rst, SHALL set:
- FSM = IDLE, cnt=0, latched address/data=0
- req_ready=1, resp_valid=0, resp_rdata=0
- bmem_read=0, bmem_write=0, bmem_addr=0, bmem_wdata=0
REQ-022 Reset asserted mid-burst SHALL abandon the transaction without a resp_valid; beats arriving after reset are ignored.

Configuration
REQ-023 SHALL support macro BMEM_RADDR_CHECK_EN.
- Defined: in RD_WAIT, a beat is stored only when bmem_raddr[31:5] equals the latched line address[31:5]; mismatching beats are dropped and cnt is unchanged.
- Undefined: bmem_raddr is unused and every bmem_rvalid beat is accepted.

Verification
REQ-024 Write, bmem_ready=1: req_write with addr 0x1ECEB014, wdata {64'h4,64'h3,64'h2,64'h1} -> bmem_addr=0x1ECEB000; bmem_wdata 1,2,3,4 on cycles 1-4; resp_valid on cycle 5.
REQ-025 Read: req_read with addr 0x00000040, beats 0xA,0xB,0xC,0xD with rvalid gaps -> bmem_read for one cycle; resp_rdata={D,C,B,A}; resp_valid the cycle after the last beat.
REQ-026 Backpressure: bmem_ready toggling 0/1 during a write -> each beat held stable until accepted; exactly 4 accepted beats; one resp_valid.
REQ-027 Simultaneous req_read and req_write in IDLE -> write performed, no bmem_read issued.
REQ-028 rst after 2 read beats -> outputs at reset values the next cycle; no resp_valid; the next read completes correctly.
REQ-029 With BMEM_RADDR_CHECK_EN, an interleaved beat with a foreign raddr -> beat dropped; the line still assembles from the 4 matching beats.
